cgp_fitness_eval: RTL and testbench

Sequential test harness that sits directly around one evolved CGP individual (4-input, 4-output combinational LUT array) on the iCE40 fabric. It drives the individual's `in*` inputs through every input vector and samples its `x*_y*` outputs after a fixed settle interval. It scores the outputs bitwise against a target truth table and reports the score to the evolution controller over a start/done handshake.

---
 rtl/cgp_pkg.sv | 17 +
 rtl/cgp_fitness_eval_popcount.sv | 18 +
 rtl/cgp_fitness_eval.sv | 146 ++++++++++++++
 tb/tb_cgp_fitness_eval.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cgp_pkg.sv
// Shared constants and the evaluation state type for the CGP fitness harness.
package cgp_pkg;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 4;
  localparam int N_VEC   = 2 ** N_IN;
  localparam int TT_W    = N_OUT * N_VEC;
  localparam int SCORE_W = $clog2(TT_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } eval_state_t;

endpackage

// File: rtl/cgp_fitness_eval_popcount.sv
// Combinational population count of a W-bit vector.
module cgp_popcount #(
  parameter  int W  = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  // Sum the set bits one at a time; W is small, so a plain adder chain is fine.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/cgp_fitness_eval.sv
// Fitness evaluator: sweeps every input vector through one CGP individual,
// samples its outputs after a settle interval and scores them bitwise
// against a target truth table.
//
// state  | meaning
// IDLE   | waiting for start; results from the last run are held
// DRIVE  | dut_in = vec, waiting SETTLE_CYCLES+1 cycles for the individual
// SAMPLE | compare registered outputs with the target row, accumulate score
// DONE   | one-cycle result strobe, then back to IDLE
module cgp_fitness_eval #(
  parameter  int N_IN          = cgp_pkg::N_IN,
  parameter  int N_OUT         = cgp_pkg::N_OUT,
  parameter  int SETTLE_CYCLES = 2,
  localparam int N_VEC         = 2 ** N_IN,
  localparam int TT_W          = N_OUT * N_VEC,
  localparam int SCORE_W       = $clog2(TT_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TT_W-1:0]    target_tt,
  output logic [N_IN-1:0]    dut_in,
  input  logic [N_OUT-1:0]   dut_out,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               perfect,
  output logic               fail_valid,
  output logic [N_IN-1:0]    fail_vec
);

  import cgp_pkg::*;

  localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int MATCH_W = $clog2(N_OUT + 1);

  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0]    LAST_VEC    = N_IN'(N_VEC - 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE   = SCORE_W'(TT_W);

  eval_state_t          state;
  eval_state_t          state_nxt;
  logic [CNT_W-1:0]     settle_cnt;
  logic [N_IN-1:0]      vec;
  logic [TT_W-1:0]      tt_q;
  logic [N_OUT-1:0]     dut_out_q;
  logic [SCORE_W-1:0]   score_acc;
  logic                 fail_valid_q;
  logic [N_IN-1:0]      fail_vec_q;
  logic [N_OUT-1:0]     expected;
  logic [N_OUT-1:0]     match_bits;
  logic [MATCH_W-1:0]   match_cnt;
  logic                 mismatch;
  logic                 last_vec;

  assign expected   = tt_q[vec*N_OUT +: N_OUT];
  assign match_bits = ~(dut_out_q ^ expected);
  assign mismatch   = |(dut_out_q ^ expected);
  assign last_vec   = (vec == LAST_VEC);

  cgp_popcount #(
    .W(N_OUT)
  ) u_popcount (
    .bits (match_bits),
    .count(match_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the settle counter runs down to zero before sampling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (settle_cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register the individual's outputs so sampling never sees a raw fabric path.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_out_q <= '0;
    end else begin
      dut_out_q <= dut_out;
    end
  end

  // Run datapath: vector/settle counters, captured target and result accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt   <= '0;
      vec          <= '0;
      tt_q         <= '0;
      score_acc    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            settle_cnt   <= SETTLE_LOAD;
            vec          <= '0;
            tt_q         <= target_tt;
            score_acc    <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
          end
        end
        DRIVE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        SAMPLE: begin
          score_acc <= score_acc + SCORE_W'(match_cnt);
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec;
          end
          if (!last_vec) begin
            vec        <= vec + 1'b1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_in     = vec;
  assign busy       = (state == DRIVE) || (state == SAMPLE);
  assign done       = (state == DONE);
  assign score      = score_acc;
  assign perfect    = (score_acc == MAX_SCORE);
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_cgp_fitness_eval.sv
// Self-checking bench for cgp_fitness_eval: a behavioural individual (LUT with
// programmable output delay) feeds two evaluators, one with SETTLE_CYCLES=2
// and one with SETTLE_CYCLES=1; results are compared with a reference model.
module tb_cgp_fitness_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] target_tt;

  logic [3:0] dut_in_a, dut_out_a, fail_vec_a;
  logic [6:0] score_a;
  logic       busy_a, done_a, perfect_a, fail_valid_a;

  logic [3:0] dut_in_b, dut_out_b, fail_vec_b;
  logic [6:0] score_b;
  logic       busy_b, done_b, perfect_b, fail_valid_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] lut [16];
  int         delay_a = 0;
  int         delay_b = 0;
  logic [3:0] pipe_a [3];
  logic [3:0] pipe_b [3];

  always #5 clk = ~clk;

  cgp_fitness_eval #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .start(start), .target_tt(target_tt),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
    .score(score_a), .perfect(perfect_a), .fail_valid(fail_valid_a), .fail_vec(fail_vec_a)
  );

  cgp_fitness_eval #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .target_tt(target_tt),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
    .score(score_b), .perfect(perfect_b), .fail_valid(fail_valid_b), .fail_vec(fail_vec_b)
  );

  // Behavioural individual: out = lut[in], visible delay_x cycles after in changes.
  always @(posedge clk) begin
    pipe_a[0] <= lut[dut_in_a];
    pipe_a[1] <= pipe_a[0];
    pipe_a[2] <= pipe_a[1];
    pipe_b[0] <= lut[dut_in_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign dut_out_a = (delay_a == 0) ? lut[dut_in_a] : pipe_a[delay_a-1];
  assign dut_out_b = (delay_b == 0) ? lut[dut_in_b] : pipe_b[delay_b-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count matching bits over all 16 vectors, note first bad vector.
  function automatic void ref_eval(input logic [63:0] tgt, output int sc,
                                   output bit fv, output int fvec);
    sc = 0; fv = 0; fvec = 0;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] diff;
      diff = lut[v] ^ tgt[v*4 +: 4];
      sc += 4 - $countones(diff);
      if (diff != 4'd0 && !fv) begin
        fv = 1;
        fvec = v;
      end
    end
  endfunction

  function automatic logic [63:0] ident_tt();
    logic [63:0] t;
    for (int v = 0; v < 16; v++) t[v*4 +: 4] = 4'(v);
    return t;
  endfunction

  task automatic set_ident_lut();
    for (int v = 0; v < 16; v++) lut[v] = 4'(v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".dut_in"},     dut_in_a,     0);
    chk({tag, ".busy"},       busy_a,       0);
    chk({tag, ".done"},       done_a,       0);
    chk({tag, ".score"},      score_a,      0);
    chk({tag, ".perfect"},    perfect_a,    0);
    chk({tag, ".fail_valid"}, fail_valid_a, 0);
    chk({tag, ".fail_vec"},   fail_vec_a,   0);
  endtask

  // One full run on instance a, timing and results checked against the model.
  task automatic run_check(input string tag, input logic [63:0] tgt);
    int  sc, fvec, cyc;
    bit  fv;
    ref_eval(tgt, sc, fv, fvec);
    target_tt = tgt;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk({tag, ".busy1"}, busy_a, 1);
    chk({tag, ".vec0"},  dut_in_a, 0);
    while (!done_a && cyc < 200) begin
      tick();
      cyc++;
      if (!done_a && (cyc % 4) == 1) chk({tag, ".vec"}, dut_in_a, (cyc - 1) / 4);
    end
    chk({tag, ".done_cyc"},   cyc, 65);
    chk({tag, ".busy_done"},  busy_a, 0);
    chk({tag, ".score"},      score_a, sc);
    chk({tag, ".perfect"},    perfect_a, (sc == 64));
    chk({tag, ".fail_valid"}, fail_valid_a, fv);
    chk({tag, ".fail_vec"},   fail_vec_a, fvec);
    tick();
    chk({tag, ".done_pulse"}, done_a, 0);
    chk({tag, ".hold"},       score_a, sc);
  endtask

  // Bounded wait for instance a to finish its current run.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!done_a && n < 200) begin
      tick();
      n++;
    end
    chk({tag, ".drain"}, done_a, 1);
    tick();
  endtask

  initial begin
    logic [63:0] t;
    int          q[$];
    int          c, dn;

    rst = 1'b1;
    start = 1'b0;
    target_tt = '0;
    set_ident_lut();
    repeat (3) tick();
    chk_zero("reset");
    chk("reset.b_score", score_b, 0);
    rst = 1'b0;
    tick();

    // Identity, full mismatch, single bit flip.
    run_check("ident", ident_tt());
    run_check("allbad", ~ident_tt());
    t = ident_tt();
    t[9*4 + 2] = ~t[9*4 + 2];
    run_check("flip9", t);

    // Randomized individuals and targets, with sparse random disagreements.
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v < 16; v++) lut[v] = 4'($urandom);
      for (int v = 0; v < 16; v++) t[v*4 +: 4] = lut[v] ^ 4'($urandom & $urandom & $urandom);
      delay_a = int'($urandom_range(0, 2));
      run_check("rand", t);
    end

    // Settle interval: 2-cycle individual is fine at SETTLE=2, too slow at SETTLE=1.
    set_ident_lut();
    delay_a = 2;
    delay_b = 2;
    run_check("settle2", ident_tt());
    chk("settle1.done_seen", fail_valid_b | perfect_b, 1);
    chk("settle1.not_perfect", score_b == 7'd64, 0);
    delay_a = 0;
    delay_b = 0;

    // start held high: accepted at 0, 66, 132, ... so done at 65, 131, 197.
    target_tt = ident_tt();
    start = 1'b1;
    for (c = 1; c <= 200; c++) begin
      tick();
      if (done_a) q.push_back(c);
    end
    start = 1'b0;
    chk("held.count", q.size(), 3);
    if (q.size() == 3) begin
      chk("held.d0", q[0], 65);
      chk("held.d1", q[1], 131);
      chk("held.d2", q[2], 197);
    end
    drain("held");

    // Extra start at cycle 20 and target change at cycle 30 are ignored.
    target_tt = ident_tt();
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (!done_a && c < 200) begin
      start = (c == 20);
      if (c == 30) target_tt = {$urandom, $urandom};
      tick();
      c++;
    end
    start = 1'b0;
    chk("midstart.done_cyc", c, 65);
    chk("midstart.score", score_a, 64);
    chk("midstart.perfect", perfect_a, 1);
    tick();

    // Reset at cycle 30 of a run discards it.
    target_tt = ident_tt();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (c = 1; c < 30; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    dn = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_a) dn++;
    end
    chk("midrst.no_done", dn, 0);
    run_check("postrst", ident_tt());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
